proc_in_fifo: RTL and testbench

Input-side buffer for the processor core: accepts words from an external producer over a valid/ready stream, stores them in a show-ahead FIFO, and serves them on the core's `io_in` port. The core reads data when `req_in` is asserted at the data address and reads status at the status address. It also raises `itr` when the fill level reaches a programmable threshold. It sits directly upstream of the processor top, driving its `io_in` and `itr` and consuming its `addr_in` and `req_in`.

---
 rtl/proc_in_fifo_pkg.sv | 14 +
 rtl/proc_in_fifo_fifo_sync.sv | 64 ++++++
 rtl/proc_in_fifo.sv | 83 ++++++++
 tb/tb_proc_in_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/proc_in_fifo_pkg.sv
// Shared definitions for processor I/O buffers: status word bit layout and
// the width of an occupancy count for a given depth.
package proc_in_fifo_pkg;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 2;

  // A count must hold 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/proc_in_fifo_fifo_sync.sv
// Generic show-ahead synchronous FIFO; push/pop requests are ignored when
// full/empty respectively, so callers may drive them unqualified.
module fifo_sync
  import proc_in_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int NUBITS = 16,
  localparam int CW     = fifo_cw(DEPTH),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NUBITS-1:0] wr_data,
  input  logic              pop,
  output logic [NUBITS-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [NUBITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rp_q];
  assign count   = count_q;

  // Pointers wrap for free since DEPTH is a power of two.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (do_push) wp_d = wp_q + PW'(1);
    if (do_pop)  rp_d = rp_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: rtl/proc_in_fifo.sv
// Processor input buffer: stream-in FIFO served on io_in, with a status
// address, a fill-threshold interrupt pulse and a sticky underflow flag.
module proc_in_fifo
  import proc_in_fifo_pkg::*;
#(
  parameter  int NUBITS = 16,
  parameter  int DEPTH  = 8,
  parameter  int NUIOIN = 2,
  parameter  int DADDR  = 0,
  parameter  int SADDR  = 1,
  parameter  int ITHR   = 1,
  localparam int CW     = fifo_cw(DEPTH),
  localparam int AW     = (NUIOIN > 1) ? $clog2(NUIOIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [AW-1:0]     addr_in,
  input  logic              req_in,
  output logic [NUBITS-1:0] io_in,
  output logic              itr,
  output logic              ovr
);

  logic [NUBITS-1:0] head;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              rd_req, push_ok, pop_ok;
  logic              itr_q, itr_d, ovr_q, ovr_d;

  assign rd_req  = req_in && (addr_in == AW'(DADDR));
  assign push_ok = s_valid && !full;
  assign pop_ok  = rd_req && !empty;
  assign s_ready = !full;
  assign itr     = itr_q;
  assign ovr     = ovr_q;

  fifo_sync #(
    .DEPTH  (DEPTH),
    .NUBITS (NUBITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (rd_req),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Count moves by at most one per cycle, so a crossing is exactly a net
  // increment out of ITHR-1.
  always_comb begin
    itr_d = push_ok && !pop_ok && (count == CW'(ITHR - 1));
    ovr_d = ovr_q || (rd_req && empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      itr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      itr_q <= itr_d;
      ovr_q <= ovr_d;
    end
  end

  always_comb begin
    io_in = '0;
    if (addr_in == AW'(DADDR)) begin
      if (!empty) io_in = head;
    end else if (addr_in == AW'(SADDR)) begin
      io_in[ST_EMPTY]            = empty;
      io_in[ST_FULL]             = full;
      io_in[ST_COUNT_LSB +: CW]  = count;
    end
  end

endmodule

// File: tb/tb_proc_in_fifo.sv
// Bench for proc_in_fifo: constant vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_proc_in_fifo;

  localparam int NB   = 16;
  localparam int DEP  = 8;
  localparam int ITHR = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [0:0]    addr_in = '0;
  logic          req_in = 1'b0;
  logic [NB-1:0] io_in;
  logic          itr, ovr;

  proc_in_fifo #(.NUBITS(NB), .DEPTH(DEP), .NUIOIN(2), .DADDR(0), .SADDR(1), .ITHR(ITHR)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .addr_in(addr_in), .req_in(req_in), .io_in(io_in), .itr(itr), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] q[$];
  bit m_ovr, m_itr;
  logic lv, la, lr;
  logic [NB-1:0] ld;

  typedef struct {
    logic v; logic [NB-1:0] d; logic a; logic r;
    logic [NB-1:0] eio; logic erdy; logic eitr; logic eovr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] m_io(input logic a);
    logic [NB-1:0] s;
    s = '0;
    if (a == 1'b0) begin
      if (q.size() != 0) s = q[0];
    end else begin
      s[0]   = (q.size() == 0);
      s[1]   = (q.size() == DEP);
      s[5:2] = 4'(q.size());
    end
    return s;
  endfunction

  // Apply inputs, settle, compare against the model (clock is low here).
  task automatic drive(input logic v, input logic [NB-1:0] d, input logic a, input logic r);
    s_valid = v; s_data = d; addr_in = a; req_in = r;
    lv = v; ld = d; la = a; lr = r;
    #1;
    chk("model_io", io_in, m_io(a));
    chk("model_ready", s_ready, q.size() != DEP);
    chk("model_itr", itr, m_itr);
    chk("model_ovr", ovr, m_ovr);
  endtask

  task automatic edge_upd();
    int old_sz;
    bit psh, pp;
    @(posedge clk);
    old_sz = q.size();
    psh = lv && (old_sz < DEP);
    pp  = lr && (la == 1'b0) && (old_sz > 0);
    if (lr && la == 1'b0 && old_sz == 0) m_ovr = 1'b1;
    if (pp)  void'(q.pop_front());
    if (psh) q.push_back(ld);
    m_itr = (old_sz < ITHR) && (q.size() >= ITHR);
    @(negedge clk);
  endtask

  task automatic cyc(input logic v, input logic [NB-1:0] d, input logic a, input logic r);
    drive(v, d, a, r);
    edge_upd();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 1'b0;
    m_itr = 1'b0;
  endtask

  // Drop reset in the middle of the low phase and expect reset values before the next edge.
  task automatic async_rst(input string tag);
    #2;
    rst = 1'b0;
    addr_in = 1'b1; req_in = 1'b0; s_valid = 1'b0;
    #1;
    chk({tag, "_io"}, io_in, 32'h0001);
    chk({tag, "_ready"}, s_ready, 1);
    chk({tag, "_itr"}, itr, 0);
    chk({tag, "_ovr"}, ovr, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h2222, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 16'h3333, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1};

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].r);
      chk($sformatf("tbl%0d_io", i), io_in, tbl[i].eio);
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d_itr", i), itr, tbl[i].eitr);
      chk($sformatf("tbl%0d_ovr", i), ovr, tbl[i].eovr);
      edge_upd();
    end

    // Fill to full, refuse a 9th word, pop while full with a push offered, then prove wrap.
    for (int i = 0; i < DEP; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b1, 1'b0);
    drive(1'b1, 16'h9999, 1'b1, 1'b0);
    chk("full_status", io_in, 32'h0022);
    chk("full_ready", s_ready, 0);
    edge_upd();
    drive(1'b1, 16'hAAAA, 1'b0, 1'b1);
    chk("full_pop_head", io_in, 32'hC000);
    edge_upd();
    drive(1'b1, 16'hAAAA, 1'b1, 1'b0);
    chk("after_pop_ready", s_ready, 1);
    chk("after_pop_status", io_in, 32'h001C);
    edge_upd();
    for (int i = 0; i < DEP; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      chk($sformatf("wrap_rd%0d", i), io_in, (i == DEP - 1) ? 32'hAAAA : 32'hC000 + 32'(i + 1));
      edge_upd();
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("ovr_sticky", ovr, 1);
    chk("drained_status", io_in, 32'h0001);
    edge_upd();

    // Async reset with 5 words stored and ovr set.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("five_status", io_in, 32'h0014);
    async_rst("arst5");
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("post_rst_status", io_in, 32'h0001);
    edge_upd();

    // Async reset while the interrupt pulse is high.
    cyc(1'b1, 16'h7777, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("itr_pulse", itr, 1);
    async_rst("arst_itr");

    // Random traffic in phases that bias towards filling, draining and mixing.
    for (int i = 0; i < 3000; i++) begin
      int ph, pv, pr;
      ph = (i / 150) % 3;
      pv = (ph == 0) ? 85 : (ph == 1) ? 20 : 55;
      pr = (ph == 0) ? 25 : (ph == 1) ? 85 : 55;
      cyc(1'($urandom_range(0, 99) < pv), 16'($urandom),
          1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < pr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
